// File: rtl/hdb3_encoding.sv
// rtl/hdb3_encoding.sv - HDB3 line encoder: NRZ bits in, tagged {pol,sub,mark} symbols out via 4-deep lookahead.
// Optional substitution counters enabled by defining HDB3_ENCODING_STATS_EN.
module hdb3_encoding #(
    parameter int STAT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       data_instruction,
    output logic [2:0] encoding_data,
    output logic       encoding_instruction
`ifdef HDB3_ENCODING_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] v_count,
    output logic [STAT_WIDTH-1:0] b_count
`endif
);

    localparam logic [1:0] TAG_NONE      = 2'd0;
    localparam logic [1:0] TAG_SUB_FIRST = 2'd1;
    localparam logic [1:0] TAG_SUB_V     = 2'd2;

    logic [3:0] stg_valid;
    logic [3:0] stg_bit;
    logic [1:0] tag0, tag1, tag2, tag3;
    logic [1:0] zero_run;
    logic       last_pol;
    logic       parity;

    logic       sub_hit;
    logic [1:0] in_tag;
    logic [1:0] tag2_fwd;
    logic [2:0] sym;
    logic       pol_next;
    logic       par_next;
    logic       emit_b;
    logic       emit_v;

    if (STAT_WIDTH > 0) begin : g_stat_width_ok
    end

    // Fourth zero in a row: the incoming entry becomes V and the oldest zero of the run,
    // currently in stage 2 and about to move to stage 3, becomes the B/0 slot.
    assign sub_hit  = !data_in && (zero_run == 2'd3);
    assign in_tag   = sub_hit ? TAG_SUB_V : TAG_NONE;
    assign tag2_fwd = sub_hit ? TAG_SUB_FIRST : tag2;

    always_comb begin
        sym      = 3'b000;
        pol_next = last_pol;
        par_next = parity;
        emit_b   = 1'b0;
        emit_v   = 1'b0;
        if (stg_valid[3]) begin
            case (tag3)
                TAG_NONE: begin
                    if (stg_bit[3]) begin
                        pol_next = ~last_pol;
                        sym      = {~last_pol, 2'b01};
                        par_next = ~parity;
                    end
                end
                TAG_SUB_FIRST: begin
                    if (!parity) begin
                        pol_next = ~last_pol;
                        sym      = {~last_pol, 2'b10};
                        emit_b   = 1'b1;
                    end
                end
                TAG_SUB_V: begin
                    sym      = {last_pol, 2'b10};
                    par_next = 1'b0;
                    emit_v   = 1'b1;
                end
                default: begin
                    sym = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_valid            <= 4'b0000;
            stg_bit              <= 4'b0000;
            tag0                 <= TAG_NONE;
            tag1                 <= TAG_NONE;
            tag2                 <= TAG_NONE;
            tag3                 <= TAG_NONE;
            zero_run             <= 2'd0;
            last_pol             <= 1'b1;
            parity               <= 1'b0;
            encoding_data        <= 3'b000;
            encoding_instruction <= 1'b0;
        end else if (data_instruction) begin
            stg_valid            <= {stg_valid[2:0], 1'b1};
            stg_bit              <= {stg_bit[2:0], data_in};
            tag0                 <= in_tag;
            tag1                 <= tag0;
            tag2                 <= tag1;
            tag3                 <= tag2_fwd;
            zero_run             <= (data_in || sub_hit) ? 2'd0 : zero_run + 2'd1;
            last_pol             <= pol_next;
            parity               <= par_next;
            encoding_data        <= sym;
            encoding_instruction <= stg_valid[3];
        end else begin
            encoding_data        <= 3'b000;
            encoding_instruction <= 1'b0;
        end
    end

`ifdef HDB3_ENCODING_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_count <= '0;
            b_count <= '0;
        end else if (data_instruction) begin
            if (emit_v && (v_count != {STAT_WIDTH{1'b1}})) begin
                v_count <= v_count + 1'b1;
            end
            if (emit_b && (b_count != {STAT_WIDTH{1'b1}})) begin
                b_count <= b_count + 1'b1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = emit_b ^ emit_v;
`endif

endmodule
